led_decoder_arbiter: RTL and testbench
======================================

# led_decoder_arbiter

Round-robin arbiter and sequencer for the shared 3-to-8 LED decoder. Up to N_REQ requesters each ask to light one LED index. The block grants the decoder to one requester at a time for a fixed hold window, drives the decoder's `switch`/`enable` inputs, and inserts a one-cycle blanking gap between owners. It sits directly upstream of the registered, active-low LED decoder (enable code 3'b100 = active).

## Interface
- N_REQ, 4: number of requesters; legal range 2..8.
- HOLD_CYCLES, 8: cycles the decoder is held enabled per grant; legal range 1..255.

- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  request vector; bit i = requester i wants the decoder.
- req_idx  in  3*N_REQ  packed LED indices; requester i at [3i+2:3i].
- grant  out  N_REQ  one-hot owner during HOLD; all-zero otherwise.
- done  out  N_REQ  one-cycle one-hot pulse when a hold completes in full.
- switch  out  3  decoder select, to decoder `switch`.
- enable  out  3  decoder enable, to decoder `enable`; 3'b100 in HOLD, 3'b000 otherwise.
- busy  out  1  high whenever state != IDLE.

## Operation
- All outputs are registered. Reset values: state IDLE, grant 0, done 0, switch 3'd0, enable 3'b000, busy 0, rr pointer 0, hold counter 0.
- FSM has three states: IDLE, HOLD, RELEASE.
- IDLE:
  - If req is zero, stay in IDLE.
  - Otherwise select the first set bit at or after the rr pointer, searching upward with wrap modulo N_REQ. Call it k.
  - Latch switch <= req_idx[k], set grant to one-hot k, set enable to 3'b100, load the counter with HOLD_CYCLES-1, set ptr to (k+1) mod N_REQ, go to HOLD.
- HOLD:
  - switch and enable stay frozen. Later changes to req_idx are ignored.
  - If req[k] is still high: decrement the counter each cycle. On the cycle the counter is 0, go to RELEASE with done[k]=1.
  - Abort: if req[k] is sampled low in HOLD, go to RELEASE next cycle with done all-zero. The pointer is not rolled back.
- RELEASE (exactly one cycle):
  - grant=0, enable=3'b000, switch keeps its last value, done as set above.
  - Always go to IDLE next.
- done is high only in the RELEASE cycle.
- Requests from other requesters during HOLD or RELEASE do not pre-empt. They are evaluated at the next IDLE.
- A requester that keeps req high is re-granted after all other active requesters have been served, so no requester starves.
- Reset in any state forces all reset values at the next edge. No done pulse is produced, and the pointer returns to 0.

## Timing
- Request-to-grant latency: req seen at edge t in IDLE gives grant/enable valid after edge t, i.e. 1 cycle.
- Hold window: HOLD_CYCLES cycles with enable=3'b100.
- Full slot per grant: 1 (IDLE) + HOLD_CYCLES + 1 (RELEASE) = HOLD_CYCLES+2 cycles.
- With HOLD_CYCLES=8, back-to-back grants start every 10 cycles.
- The downstream decoder adds 1 cycle. The LED pattern 8'hFF minus bit switch is visible one cycle after enable rises, and returns to 8'hFF one cycle after RELEASE.
- HOLD_CYCLES=1 is legal: HOLD lasts one cycle, and done follows on the next cycle.
- Abort latency: req[k] low at a HOLD edge gives enable=3'b000 after the next edge.
- Counter width is sized to hold HOLD_CYCLES-1. The counter never wraps, because HOLD exits at 0.

## Test plan
- **Reset:** rst=1 for 2 cycles with req=4'b1111.
  - Required: grant=0, done=0, enable=3'b000, switch=0, busy=0.
  - After release with req=0, the block stays IDLE indefinitely.
- **Single grant** (N_REQ=4, HOLD_CYCLES=8): req=4'b0001, idx0=5 from cycle 0.
  - Cycles 1–8: grant=4'b0001, switch=5, enable=3'b100, downstream led=8'hDF from cycle 2.
  - Cycle 9: done=4'b0001, enable=3'b000.
  - Cycle 10: IDLE, then re-grant at cycle 11.
- **Round robin:** req=4'b1111 held, idx_i=i.
  - Grant order 0,1,2,3,0, with grant starts at cycles 1, 11, 21, 31, 41.
  - Exactly one done pulse per slot, each one-hot for that slot's owner.
- **Abort:** single grant to requester 0; drop req[0] at the 3rd HOLD cycle while req[2] is high.
  - grant and enable clear on the next cycle, with no done pulse.
  - Then one RELEASE cycle, one IDLE cycle, and requester 2 is granted.
- **Reset mid-HOLD:** assert rst during a grant to requester 2.
  - All outputs are zero after the edge, with no done pulse.
  - Then req=4'b1010 grants requester 1 first, confirming the pointer returned to 0.
- **Index change during HOLD:** change idx0 from 5 to 2 mid-hold.
  - switch stays 5 until RELEASE.
  - The next grant to requester 0 uses 2.

Source files
------------

// File: rtl/led_decoder_arbiter.sv
// led_decoder_arbiter: round-robin owner selection and hold/blank sequencing for a shared 3-to-8 LED decoder
module led_decoder_arbiter #(
  parameter int N_REQ = 4,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [3*N_REQ-1:0]   req_idx,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     done,
  output logic [2:0]           switch,
  output logic [2:0]           enable,
  output logic                 busy
);
  localparam int CW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam int PW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, HOLD, RELEASE} state_t;
  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_ptr, r_k, w_k;
  logic [N_REQ-1:0] r_grant, r_done;
  logic [2:0] r_switch, r_enable;
  logic r_busy, w_found;
  assign grant = r_grant;
  assign done = r_done;
  assign switch = r_switch;
  assign enable = r_enable;
  assign busy = r_busy;
  always_comb begin
    w_found = 1'b0;
    w_k = '0;
    for (int i = 0; i < N_REQ; i++)
      if (!w_found && req[(int'(r_ptr) + i) % N_REQ]) begin
        w_found = 1'b1;
        w_k = PW'((int'(r_ptr) + i) % N_REQ);
      end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_ptr <= '0;
      r_k <= '0;
      r_grant <= '0;
      r_done <= '0;
      r_switch <= '0;
      r_enable <= '0;
      r_busy <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= '0;
          if (w_found) begin
            r_state <= HOLD;
            r_k <= w_k;
            r_switch <= req_idx[3*int'(w_k) +: 3];
            r_grant <= N_REQ'(1) << w_k;
            r_enable <= 3'b100;
            r_cnt <= CW'(HOLD_CYCLES - 1);
            r_ptr <= w_k == PW'(N_REQ - 1) ? '0 : w_k + 1'b1;
            r_busy <= 1'b1;
          end
        end
        HOLD: begin
          if (!req[r_k] || r_cnt == '0) begin
            r_state <= RELEASE;
            r_done <= req[r_k] ? r_grant : '0;
            r_grant <= '0;
            r_enable <= 3'b000;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RELEASE: begin
          r_state <= IDLE;
          r_done <= '0;
          r_busy <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_led_decoder_arbiter.sv
// tb_led_decoder_arbiter: slot-level reference model plus directed literal checks for the LED decoder arbiter
module tb_led_decoder_arbiter;
  localparam int N = 4;
  localparam int HOLD = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = 4'b1111;
  logic [3*N-1:0] req_idx = '0;
  logic [N-1:0] grant, done;
  logic [2:0] switch, enable;
  logic busy;
  logic [2:0] grant1, done1, switch1, enable1;
  logic busy1;
  int n_tests = 0;
  int n_fail = 0;
  int c = 0;
  led_decoder_arbiter #(.N_REQ(N), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .req_idx(req_idx),
    .grant(grant), .done(done), .switch(switch), .enable(enable), .busy(busy)
  );
  led_decoder_arbiter #(.N_REQ(3), .HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .req(req[2:0]), .req_idx(req_idx[8:0]),
    .grant(grant1), .done(done1), .switch(switch1), .enable(enable1), .busy(busy1)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  int m_own = -1;
  int m_left = 0;
  int m_ptr = 0;
  bit m_rel = 0;
  bit m_valid = 0;
  logic [N-1:0] e_grant = '0, e_done = '0;
  logic [2:0] e_switch = '0, e_enable = '0;
  logic e_busy = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      m_own = -1; m_left = 0; m_ptr = 0; m_rel = 0; m_valid = 1;
      e_grant = '0; e_done = '0; e_switch = '0; e_enable = '0; e_busy = 1'b0;
    end else if (m_rel) begin
      m_rel = 0; e_done = '0; e_busy = 1'b0;
    end else if (m_own >= 0) begin
      m_left--;
      if (!req[m_own] || m_left == 0) begin
        e_done = req[m_own] ? N'(1 << m_own) : '0;
        e_grant = '0; e_enable = 3'b000; m_rel = 1; m_own = -1;
      end
    end else if (req != '0) begin
      for (int i = 0; i < N; i++)
        if (m_own < 0 && req[(m_ptr + i) % N]) m_own = (m_ptr + i) % N;
      e_grant = N'(1 << m_own);
      e_switch = 3'((req_idx >> (3 * m_own)) & 12'd7);
      e_enable = 3'b100; e_busy = 1'b1; m_left = HOLD; m_ptr = (m_own + 1) % N;
    end
  end
  always @(negedge clk) if (m_valid) begin
    chk("grant", 32'(grant), 32'(e_grant));
    chk("done", 32'(done), 32'(e_done));
    chk("switch", 32'(switch), 32'(e_switch));
    chk("enable", 32'(enable), 32'(e_enable));
    chk("busy", 32'(busy), 32'(e_busy));
  end
  task automatic go(input int n);
    while (c < n) begin
      @(negedge clk);
      c++;
    end
  endtask
  task automatic reset_pulse;
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    c = 0;
  endtask
  initial begin
    go(2);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_enable", 32'(enable), 0);
    chk("rst_switch", 32'(switch), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0; req = '0; c = 0;
    go(5);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_grant", 32'(grant), 0);
    c = 0; req = 4'b0001; req_idx = 12'd5;
    go(1);
    chk("sg_grant_c1", 32'(grant), 1);
    chk("sg_switch_c1", 32'(switch), 5);
    chk("sg_enable_c1", 32'(enable), 4);
    go(8);
    chk("sg_grant_c8", 32'(grant), 1);
    go(9);
    chk("sg_done_c9", 32'(done), 1);
    chk("sg_enable_c9", 32'(enable), 0);
    go(10);
    chk("sg_busy_c10", 32'(busy), 0);
    go(11);
    chk("sg_regrant_c11", 32'(grant), 1);
    req = '0;
    go(14);
    reset_pulse();
    req = 4'b1111; req_idx = {3'd3, 3'd2, 3'd1, 3'd0};
    for (int s = 0; s < 5; s++) begin
      go(1 + 10 * s);
      chk("rr_grant", 32'(grant), 32'(1 << (s % 4)));
      chk("rr_switch", 32'(switch), 32'(s % 4));
      go(9 + 10 * s);
      chk("rr_done", 32'(done), 32'(1 << (s % 4)));
    end
    req = '0;
    go(52);
    reset_pulse();
    req = 4'b0101; req_idx = {3'd0, 3'd6, 3'd0, 3'd5};
    go(3);
    chk("ab_grant_c3", 32'(grant), 1);
    req = 4'b0100;
    go(4);
    chk("ab_grant_c4", 32'(grant), 0);
    chk("ab_enable_c4", 32'(enable), 0);
    chk("ab_done_c4", 32'(done), 0);
    go(5);
    chk("ab_busy_c5", 32'(busy), 0);
    go(6);
    chk("ab_grant2_c6", 32'(grant), 4);
    chk("ab_switch2_c6", 32'(switch), 6);
    req = '0;
    go(9);
    reset_pulse();
    req = 4'b0100;
    go(3);
    chk("rh_grant_c3", 32'(grant), 4);
    rst = 1'b1;
    go(4);
    chk("rh_grant_c4", 32'(grant), 0);
    chk("rh_done_c4", 32'(done), 0);
    chk("rh_enable_c4", 32'(enable), 0);
    chk("rh_switch_c4", 32'(switch), 0);
    chk("rh_busy_c4", 32'(busy), 0);
    rst = 1'b0; req = 4'b1010;
    go(5);
    chk("rh_ptr0_c5", 32'(grant), 2);
    req = '0;
    go(8);
    reset_pulse();
    req = 4'b0001; req_idx = 12'd5;
    go(4);
    req_idx = 12'd2;
    go(8);
    chk("ix_switch_c8", 32'(switch), 5);
    go(9);
    chk("ix_switch_c9", 32'(switch), 5);
    chk("ix_done_c9", 32'(done), 1);
    go(11);
    chk("ix_switch_c11", 32'(switch), 2);
    chk("ix_grant_c11", 32'(grant), 1);
    req = '0;
    go(14);
    reset_pulse();
    req = 4'b0001; req_idx = 12'd5;
    go(1);
    chk("h1_grant_c1", 32'(grant1), 1);
    chk("h1_enable_c1", 32'(enable1), 4);
    chk("h1_switch_c1", 32'(switch1), 5);
    go(2);
    chk("h1_done_c2", 32'(done1), 1);
    chk("h1_enable_c2", 32'(enable1), 0);
    go(3);
    chk("h1_busy_c3", 32'(busy1), 0);
    go(4);
    chk("h1_regrant_c4", 32'(grant1), 1);
    req = '0;
    go(8);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
